ntt_bank_mapper: RTL and testbench

Downstream consumer of the NTT address generator's `Order` stream. It collects each group of R = 2^RADIX_K consecutive butterfly indices and maps each index to a (bank, bank-address) pair using conflict-free digit-sum banking. It reorders each group into bank-lane order and queues completed groups in a small FIFO. The FIFO feeds the multi-bank memory read/write controller over a valid/ready handshake.

---
 rtl/ntt_bank_mapper.sv | 219 +++++++++++++++++++++
 tb/tb_ntt_bank_mapper.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bank_mapper.sv
// ---------------------------------------------------------------------------
// ntt_bank_mapper
//
// Consumes the NTT address generator's butterfly-index stream. It collects
// each group of R = 2^RADIX_K consecutive indices and maps every index to a
// bank (sum of its RADIX_K-bit digits mod R) and a bank address (index with
// the lowest digit removed). It reorders the group into bank-lane order and
// queues it in a small FIFO that feeds the multi-bank memory controller.
//
// Ports
//   clk, rst       single rising-edge clock, synchronous active-high reset
//   order_in       butterfly index; only bits [LOGN-1:0] are used
//   order_valid    order_in valid this cycle (no backpressure to the source)
//   stage_done     pulse: the address generator finished all stages
//   grp_valid      FIFO head group available
//   grp_ready      consumer accepts the head group
//   grp_addr       lane b = [b*AW +: AW], bank address for bank b
//   grp_perm       lane b = [b*RADIX_K +: RADIX_K], arrival index of that beat
//   overflow       sticky: completed group dropped on a full FIFO
//   bank_conflict  sticky: two beats of one group hit the same bank
//   partial_err    sticky: stage_done arrived mid-group
//   done           pulse: everything delivered after stage_done
// ---------------------------------------------------------------------------
module ntt_bank_mapper #(
    parameter  int D_WIDTH    = 16,
    parameter  int LOGN       = 10,
    parameter  int RADIX_K    = 2,
    parameter  int FIFO_DEPTH = 4,
    localparam int R          = 1 << RADIX_K,
    localparam int AW         = LOGN - RADIX_K
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [D_WIDTH-1:0]     order_in,
    input  logic                   order_valid,
    input  logic                   stage_done,
    output logic                   grp_valid,
    input  logic                   grp_ready,
    output logic [R*AW-1:0]        grp_addr,
    output logic [R*RADIX_K-1:0]   grp_perm,
    output logic                   overflow,
    output logic                   bank_conflict,
    output logic                   partial_err,
    output logic                   done
);

    localparam int                 ND            = LOGN / RADIX_K;
    localparam int                 PW            = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [RADIX_K-1:0] CNT_LAST      = RADIX_K'(R - 1);
    localparam logic [PW:0]        FIFO_FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Per-beat bank mapping
    // ------------------------------------------------------------------
    logic [RADIX_K-1:0] beat_bank;
    logic [AW-1:0]      beat_addr;

    // NOTE: blocking assignments in always_comb; the accumulator has to see
    // its own update on every loop iteration.
    always_comb begin
        beat_bank = '0;
        for (int i = 0; i < ND; i++) begin
            // RADIX_K-bit wrap-around gives the mod-R reduction for free.
            beat_bank = beat_bank + order_in[i*RADIX_K +: RADIX_K];
        end
    end

    assign beat_addr = order_in[LOGN-1:RADIX_K];

    generate
        if (D_WIDTH > LOGN) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^order_in[D_WIDTH-1:LOGN];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [RADIX_K-1:0]   cnt_q, cnt_d;
    logic [R-1:0]         occ_q, occ_d;
    logic [R*AW-1:0]      stg_addr_q, stg_addr_d;
    logic [R*RADIX_K-1:0] stg_perm_q, stg_perm_d;

    logic                 push_vld_q;
    logic [R*AW-1:0]      push_addr_q;
    logic [R*RADIX_K-1:0] push_perm_q;

    logic [R*AW-1:0]      fifo_addr_mem [FIFO_DEPTH];
    logic [R*RADIX_K-1:0] fifo_perm_mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PW:0]          count_q, count_d;

    logic                 overflow_q, conflict_q, partial_q;
    logic                 done_pending_q, done_pending_d;

    logic grp_complete, conflict_set, partial_set;
    logic fifo_empty, fifo_full, pop, push_wr, push_drop, done_fire;

    // ------------------------------------------------------------------
    // Collector: scatter each beat into its bank lane
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        cnt_d        = cnt_q;
        occ_d        = occ_q;
        stg_addr_d   = stg_addr_q;
        stg_perm_d   = stg_perm_q;
        grp_complete = 1'b0;
        conflict_set = 1'b0;

        if (order_valid) begin
            stg_addr_d[beat_bank*AW +: AW]           = beat_addr;
            stg_perm_d[beat_bank*RADIX_K +: RADIX_K] = cnt_q;
            conflict_set                             = occ_q[beat_bank];
            occ_d[beat_bank]                         = 1'b1;
            if (cnt_q == CNT_LAST) begin
                grp_complete = 1'b1;
                cnt_d        = '0;
                occ_d        = '0;
            end else begin
                cnt_d = cnt_q + RADIX_K'(1);
            end
        end

        // A group still open after this cycle's beat is discarded.
        partial_set = stage_done && (cnt_d != '0);
        if (partial_set) begin
            cnt_d = '0;
            occ_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL_CNT);
    assign pop        = !fifo_empty && grp_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_wr    = push_vld_q && (!fifo_full || pop);
    assign push_drop  = push_vld_q && fifo_full && !pop;

    always_comb begin
        count_d = count_q;
        unique case ({push_wr, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    assign done_fire      = done_pending_q && (cnt_q == '0) && !push_vld_q && fifo_empty;
    assign done_pending_d = stage_done || (done_pending_q && !done_fire);

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments for all clocked state, so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            occ_q          <= '0;
            push_vld_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            conflict_q     <= 1'b0;
            partial_q      <= 1'b0;
            done_pending_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            occ_q          <= occ_d;
            push_vld_q     <= grp_complete;
            count_q        <= count_d;
            done_pending_q <= done_pending_d;
            if (push_wr)      wr_ptr_q   <= wr_ptr_q + PW'(1);
            if (pop)          rd_ptr_q   <= rd_ptr_q + PW'(1);
            if (push_drop)    overflow_q <= 1'b1;
            if (conflict_set) conflict_q <= 1'b1;
            if (partial_set)  partial_q  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers and FIFO storage
    // ------------------------------------------------------------------
    // NOTE: data-only storage is deliberately not reset; occupancy, the
    // push-stage valid and the FIFO pointers decide what is meaningful.
    always_ff @(posedge clk) begin
        stg_addr_q <= stg_addr_d;
        stg_perm_q <= stg_perm_d;
        if (grp_complete) begin
            // Captures the staging image including the completing beat.
            push_addr_q <= stg_addr_d;
            push_perm_q <= stg_perm_d;
        end
        if (push_wr) begin
            fifo_addr_mem[wr_ptr_q] <= push_addr_q;
            fifo_perm_mem[wr_ptr_q] <= push_perm_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign grp_valid     = !fifo_empty;
    // Masked while empty so the unreset storage never shows on the port.
    assign grp_addr      = fifo_empty ? '0 : fifo_addr_mem[rd_ptr_q];
    assign grp_perm      = fifo_empty ? '0 : fifo_perm_mem[rd_ptr_q];
    assign overflow      = overflow_q;
    assign bank_conflict = conflict_q;
    assign partial_err   = partial_q;
    assign done          = done_fire;

endmodule

// File: tb/tb_ntt_bank_mapper.sv
module tb_ntt_bank_mapper;

    localparam int D_WIDTH    = 16;
    localparam int LOGN       = 10;
    localparam int RADIX_K    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int R          = 1 << RADIX_K;
    localparam int AW         = LOGN - RADIX_K;
    localparam int N          = 1 << LOGN;
    localparam int NGRP       = N / R;
    localparam int NSTAGE     = LOGN / RADIX_K;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [D_WIDTH-1:0]   order_in;
    logic                 order_valid;
    logic                 stage_done;
    logic                 grp_valid;
    logic                 grp_ready;
    logic [R*AW-1:0]      grp_addr;
    logic [R*RADIX_K-1:0] grp_perm;
    logic                 overflow;
    logic                 bank_conflict;
    logic                 partial_err;
    logic                 done;

    always #5 clk = ~clk;

    ntt_bank_mapper #(
        .D_WIDTH   (D_WIDTH),
        .LOGN      (LOGN),
        .RADIX_K   (RADIX_K),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .order_in     (order_in),
        .order_valid  (order_valid),
        .stage_done   (stage_done),
        .grp_valid    (grp_valid),
        .grp_ready    (grp_ready),
        .grp_addr     (grp_addr),
        .grp_perm     (grp_perm),
        .overflow     (overflow),
        .bank_conflict(bank_conflict),
        .partial_err  (partial_err),
        .done         (done)
    );

    typedef struct packed {
        logic [R*AW-1:0]      addr;
        logic [R*RADIX_K-1:0] perm;
        logic [R-1:0]         mask;   // lanes written by some beat of the group
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   passed     = 0;
    int   pops       = 0;
    int   dones      = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Reference model: digit sum of the index in base R, reduced mod R.
    function automatic int bank_of(input int o);
        int v;
        int s;
        v = o % N;
        s = 0;
        for (int d = 0; d < NSTAGE; d++) begin
            s += v % R;
            v /= R;
        end
        return s % R;
    endfunction

    // Reference model of one group: later arrivals overwrite earlier ones.
    function automatic exp_t build_exp(input int o0, input int o1, input int o2, input int o3);
        int   o[4];
        int   b;
        exp_t e;
        o = '{o0, o1, o2, o3};
        e = '0;
        for (int i = 0; i < R; i++) begin
            b = bank_of(o[i]);
            e.addr[b*AW +: AW]           = AW'((o[i] % N) / R);
            e.perm[b*RADIX_K +: RADIX_K] = RADIX_K'(i);
            e.mask[b]                    = 1'b1;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) grp_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Upper bits carry random junk; the DUT must ignore them.
    task automatic send_beat(input int o, input bit sd);
        order_in    = D_WIDTH'(o) | (D_WIDTH'($urandom_range(0, 63)) << LOGN);
        order_valid = 1'b1;
        stage_done  = sd;
        step();
        order_valid = 1'b0;
        stage_done  = 1'b0;
    endtask

    task automatic send_group(input int o0, input int o1, input int o2, input int o3,
                              input bit expect_it, input bit sd_last);
        if (expect_it) sb.push_back(build_exp(o0, o1, o2, o3));
        send_beat(o0, 1'b0);
        send_beat(o1, 1'b0);
        send_beat(o2, 1'b0);
        send_beat(o3, sd_last);
    endtask

    task automatic send_stride(input int base, input int stride, input bit expect_it, input bit sd_last);
        send_group(base, base + stride, base + 2*stride, base + 3*stride, expect_it, sd_last);
    endtask

    task automatic wait_drain(input string name, input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) step();
        check(name, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every accepted group.
    always @(negedge clk) begin : monitor
        exp_t                 e;
        logic [R*AW-1:0]      am;
        logic [R*RADIX_K-1:0] pm;
        if (done) dones++;
        if (!rst && grp_valid && grp_ready) begin
            pops++;
            if (sb.size() == 0) begin
                check("grp_expected", 64'(sb.size()), 64'd1);
            end else begin
                e  = sb.pop_front();
                am = '0;
                pm = '0;
                for (int b = 0; b < R; b++) begin
                    if (e.mask[b]) begin
                        am[b*AW +: AW]           = '1;
                        pm[b*RADIX_K +: RADIX_K] = '1;
                    end
                end
                check("grp_addr", 64'(grp_addr & am), 64'(e.addr & am));
                check("grp_perm", 64'(grp_perm & pm), 64'(e.perm & pm));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int p0;
        int d0;
        exp_t head;

        rst         = 1'b1;
        order_valid = 1'b0;
        order_in    = '0;
        stage_done  = 1'b0;
        grp_ready   = 1'b0;

        // Reset held 3 cycles with beats arriving: all ignored.
        for (int i = 0; i < 3; i++) begin
            order_valid = 1'b1;
            order_in    = D_WIDTH'($urandom);
            step();
        end
        check("rst_grp_valid", 64'(grp_valid), 64'd0);
        check("rst_data",      64'({grp_addr, grp_perm}), 64'd0);
        check("rst_flags",     64'({overflow, bank_conflict, partial_err, done}), 64'd0);
        rst         = 1'b0;
        order_valid = 1'b0;
        repeat (3) step();
        check("no_grp_after_rst", 64'(grp_valid), 64'd0);

        // stage_done while idle: done in the next cycle, for one cycle.
        stage_done = 1'b1;
        step();
        stage_done = 1'b0;
        check("done_idle_t1", 64'(done), 64'd1);
        step();
        check("done_one_cycle", 64'(done), 64'd0);

        // Stage-0 group, two-cycle latency.
        grp_ready = 1'b1;
        send_group(0, 256, 512, 768, 1'b1, 1'b0);
        check("s0_not_yet_t1", 64'(grp_valid), 64'd0);
        step();
        check("s0_valid_t2", 64'(grp_valid), 64'd1);
        check("s0_addr", 64'(grp_addr), 64'({8'd192, 8'd128, 8'd64, 8'd0}));
        check("s0_perm", 64'(grp_perm), 64'({2'd3, 2'd2, 2'd1, 2'd0}));
        check("s0_flags", 64'({overflow, bank_conflict, partial_err}), 64'd0);

        // Stage-1 permutation.
        send_group(5, 69, 133, 197, 1'b1, 1'b0);
        step();
        check("s1_valid", 64'(grp_valid), 64'd1);
        check("s1_addr", 64'(grp_addr), 64'({8'd17, 8'd1, 8'd49, 8'd33}));
        check("s1_perm", 64'(grp_perm), 64'({2'd1, 2'd0, 2'd3, 2'd2}));
        check("s1_conflict", 64'(bank_conflict), 64'd0);
        wait_drain("s1_drain", 10);

        // Backpressure: fill the FIFO, then drop a 5th group.
        grp_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) send_stride(16*i + 1, 4, 1'b1, 1'b0);
        step();
        step();
        head = build_exp(1, 5, 9, 13);
        check("full_valid", 64'(grp_valid), 64'd1);
        check("full_head", 64'(grp_addr), 64'(head.addr));
        check("full_no_ovf", 64'(overflow), 64'd0);
        send_stride(146, 4, 1'b0, 1'b0);
        step();
        step();
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_head_stable", 64'({grp_addr, grp_perm}), 64'({head.addr, head.perm}));
        p0 = pops;
        grp_ready = 1'b1;
        wait_drain("ovf_drain", 20);
        step();
        check("ovf_pop_count", 64'(pops - p0), 64'(FIFO_DEPTH));
        check("ovf_empty", 64'(grp_valid), 64'd0);

        // Same again, but a pop coincides with the 5th push: no overflow.
        rst = 1'b1;
        step();
        rst       = 1'b0;
        grp_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) send_stride(16*i + 2, 4, 1'b1, 1'b0);
        step();
        step();
        check("full2_valid", 64'(grp_valid), 64'd1);
        send_stride(147, 4, 1'b1, 1'b0);
        grp_ready = 1'b1;
        step();
        grp_ready = 1'b0;
        step();
        step();
        check("no_ovf_on_pop", 64'(overflow), 64'd0);
        p0 = pops;
        grp_ready = 1'b1;
        wait_drain("full2_drain", 20);
        check("full2_pop_count", 64'(pops - p0), 64'(FIFO_DEPTH));

        // Conflict (1 and 4 share bank 1), then a partial group at stage_done.
        send_group(0, 1, 4, 5, 1'b1, 1'b0);
        step();
        step();
        check("conflict_set", 64'(bank_conflict), 64'd1);
        d0 = dones;
        send_beat(8, 1'b0);
        send_beat(12, 1'b0);
        stage_done = 1'b1;
        step();
        stage_done = 1'b0;
        check("partial_set", 64'(partial_err), 64'd1);
        for (int i = 0; i < 20; i++) step();
        check("partial_done_once", 64'(dones - d0), 64'd1);
        check("partial_drained", 64'(sb.size()), 64'd0);
        // Collector restarts at arrival index 0.
        send_group(2, 6, 10, 14, 1'b1, 1'b0);
        wait_drain("after_partial_drain", 10);

        // Full transform; a half group before reset must be forgotten.
        send_beat(3, 1'b0);
        send_beat(7, 1'b0);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        rand_ready = 1'b1;
        p0 = pops;
        d0 = dones;
        for (int s = 0; s < NSTAGE; s++) begin
            int stride;
            stride = 1 << (RADIX_K * (NSTAGE - 1 - s));
            for (int g = 0; g < NGRP; g++) begin
                int base;
                base = (g / stride) * stride * R + (g % stride);
                send_stride(base, stride, 1'b1,
                            (s == NSTAGE - 1) && (g == NGRP - 1));
            end
        end
        for (int i = 0; i < 300 && (sb.size() != 0 || dones == d0); i++) step();
        repeat (5) step();
        check("full_groups", 64'(pops - p0), 64'(NSTAGE * NGRP));
        check("full_sb_empty", 64'(sb.size()), 64'd0);
        check("full_done_once", 64'(dones - d0), 64'd1);
        check("full_flags", 64'({overflow, bank_conflict, partial_err}), 64'd0);

        rand_ready = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
